vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares VRAM BRAM port A between the host register path and an internal bulk engine.
- The host path is the AXI-lite slave, for single-word reads and writes.
- The bulk engine performs CLEAR (fill the whole screen) and SCROLL (move every text row up one row, then fill the last row).
- Port B stays owned by the pixel path.

Parameters:
- WORDS, 600, number of 32-bit VRAM words (80x30 glyphs, 4 glyphs per word).
- ROW_WORDS, 20, words per text row.
- AW, 10, word-address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  word address.
- host_wdata  in  32  write data.
- host_wstrb  in  4  byte strobes.
- host_gnt  out  1  access taken this cycle.
- host_rvalid  out  1  read data valid.
- host_rdata  out  32  read data.
- cmd_valid  in  1  bulk command strobe.
- cmd_op  in  2  01 CLEAR, 10 SCROLL, others no-op.
- cmd_fill  in  32  fill word.
- cmd_ready  out  1  engine idle.
- busy  out  1  engine active.
- done  out  1  one-cycle completion pulse.
- bram_ena  out  1  port A enable.
- bram_wea  out  4  byte write enables.
- bram_addra  out  AW  port A address.
- bram_dina  out  32  port A write data.
- bram_douta  in  32  port A read data; 1-cycle latency.

Behaviour:
- Clocking and reset: one clock, Clk; Reset is synchronous and active-high.
  - Reset forces host_rvalid=0, host_rdata=0, busy=0, done=0, state=IDLE, counters=0, fill register=0.
  - No BRAM access is issued in a reset cycle.
  - Reset mid-command aborts the command; words already written stay written.
- Priority: the host has absolute priority, so host_gnt = host_req (combinational) whenever Reset=0.
  - In a host cycle, port A is driven from host_*; wea = host_wstrb when host_we, else 0.
- Host out-of-range access (host_addr >= WORDS):
  - The host is still granted, but ena=0 and wea=0.
  - A read returns rdata=0 with rvalid the next cycle.
- Host read return:
  - host_rvalid is asserted exactly 1 cycle after a granted read.
  - host_rdata is registered from bram_douta and holds until the next host read returns.
- Engine stall: the engine issues a port A access only in a cycle with host_req=0; otherwise it holds state and counters.
- Read-return ownership: a registered owner tag (HOST/ENGINE) records who issued the previous read, so the returning bram_douta goes to the correct destination.
- Command acceptance:
  - cmd_ready = (state==IDLE).
  - cmd_valid with cmd_ready and op CLEAR/SCROLL latches cmd_fill and idx=0, and enters CLR or SCR_RD next cycle.
  - busy is high from the following cycle.
  - No-op opcodes are ignored.
  - cmd_valid while busy is ignored (no queueing).
- FSM states: IDLE, CLR, SCR_RD, SCR_WR, FILL, DONE.
  - CLR: write fill word to idx with wea=1111; idx++; after idx=WORDS-1 go to DONE.
  - SCR_RD: read addr idx+ROW_WORDS, then go to SCR_WR.
    - The returning data is captured into a hold register in the next cycle, even if the host owns that cycle.
  - SCR_WR: write the hold register to idx; idx++.
    - After idx=WORDS-ROW_WORDS-1, go to FILL with idx=WORDS-ROW_WORDS; otherwise return to SCR_RD.
  - FILL: write fill word to idx; after idx=WORDS-1 go to DONE.
  - DONE: one cycle with done=1 and busy=0, then IDLE.
- Uncontended timing:
  - CLEAR = 600 access cycles.
  - SCROLL = 580×2 + 20 = 1180 access cycles.
  - done follows the last write by 1 cycle.
- Arithmetic: idx is AW bits; idx+ROW_WORDS is computed in AW+1 bits and never exceeds WORDS-1 in SCR_RD.

Decomposition:
- Package vram_pkg holds:
  - the WORDS, ROW_WORDS and AW constants;
  - the cmd_op enum (OP_NOP, OP_CLEAR, OP_SCROLL);
  - the engine state enum;
  - the owner-tag enum.
- Sub-module vram_bulk_engine holds the FSM, idx counter, fill and hold registers, and request/address/data outputs, with a stall input.
- The top level does priority muxing, range check, owner tag and host read return.

Test Plan:
- Host write addr 5, data 32'hDEADBEEF, wstrb 1111, then read addr 5 → gnt same cycle; rvalid 1 cycle after the read with rdata DEADBEEF.
- CLEAR with fill 32'h20202020 and no host traffic:
  - busy for 600 cycles, then a single done pulse;
  - readback of addrs 0, 299 and 599 returns 20202020.
- SCROLL after preloading word i = i:
  - done after 1180 busy cycles;
  - word 0 = 20, word 579 = 599, words 580..599 = fill.
- Host reads asserted on alternating cycles during SCROLL:
  - host rdata is always correct;
  - the final image matches the uncontended SCROLL;
  - done is delayed by the exact number of stolen cycles.
- Host read addr 600 and host write addr 700 → no BRAM enable; read returns 0 with rvalid.
- Reset asserted 50 cycles into CLEAR:
  - next cycle busy=0, cmd_ready=1 and no done;
  - a new CLEAR then completes normally.
- cmd_valid while busy, and cmd_op=11 while idle → both ignored; busy stays unaffected.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// Shared constants and enums for the VRAM port A arbiter and its bulk engine.
// Geometry: 80x30 glyphs, 4 glyphs per 32-bit word.
package vram_pkg;

  localparam int WORDS     = 600;
  localparam int ROW_WORDS = 20;
  localparam int AW        = 10;

  localparam logic [AW-1:0] LAST_IDX     = AW'(WORDS - 1);
  localparam logic [AW-1:0] SCR_LAST_IDX = AW'(WORDS - ROW_WORDS - 1);

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SCROLL = 2'b10
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL,
    ST_DONE
  } eng_state_e;

  typedef enum logic {
    OWN_HOST,
    OWN_ENGINE
  } owner_e;

  function automatic logic is_bulk_op(input logic [1:0] op);
    return (op == OP_CLEAR) || (op == OP_SCROLL);
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Host, bulk-command and BRAM port A signals of the arbiter.
// slave = arbiter side, master = host/command/BRAM side.
interface vram_port_arbiter_if;
  import vram_pkg::*;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [3:0]    host_wstrb;
  logic          host_gnt;
  logic          host_rvalid;
  logic [31:0]   host_rdata;

  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_fill;
  logic          cmd_ready;
  logic          busy;
  logic          done;

  logic          bram_ena;
  logic [3:0]    bram_wea;
  logic [AW-1:0] bram_addra;
  logic [31:0]   bram_dina;
  logic [31:0]   bram_douta;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_wstrb,
    input  cmd_valid, cmd_op, cmd_fill,
    input  bram_douta,
    output host_gnt, host_rvalid, host_rdata,
    output cmd_ready, busy, done,
    output bram_ena, bram_wea, bram_addra, bram_dina
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_wstrb,
    output cmd_valid, cmd_op, cmd_fill,
    output bram_douta,
    input  host_gnt, host_rvalid, host_rdata,
    input  cmd_ready, busy, done,
    input  bram_ena, bram_wea, bram_addra, bram_dina
  );

endinterface

// File: rtl/vram_port_arbiter_bulk_engine.sv
// CLEAR / SCROLL engine for VRAM port A; freezes whenever stall is high.
//   state     | meaning
//   ST_IDLE   | waiting for a command, cmd_ready=1
//   ST_CLR    | write fill word to idx, whole screen
//   ST_SCR_RD | read word idx+ROW_WORDS
//   ST_SCR_WR | write read-back word to idx
//   ST_FILL   | write fill word to the last text row
//   ST_DONE   | one-cycle completion pulse
module vram_bulk_engine
  import vram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [31:0]   cmd_fill,
  input  logic          rd_ret,
  input  logic [31:0]   rd_data,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic          req,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata
);

  eng_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   fill_q, fill_d;
  logic [31:0]   hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      // captured even when the host steals the cycle after our read
      if (rd_ret) hold_q <= rd_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = idx_q;
    wdata     = fill_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && is_bulk_op(cmd_op)) begin
          fill_d  = cmd_fill;
          idx_d   = '0;
          state_d = (cmd_op == OP_CLEAR) ? ST_CLR : ST_SCR_RD;
        end
      end
      ST_CLR, ST_FILL: begin
        busy = 1'b1;
        req  = 1'b1;
        we   = 1'b1;
        if (!stall) begin
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + AW'(1);
        end
      end
      ST_SCR_RD: begin
        busy = 1'b1;
        req  = 1'b1;
        addr = idx_q + AW'(ROW_WORDS);
        if (!stall) state_d = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        busy  = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        // read data lands this cycle unless the host took the cycle in between
        wdata = rd_ret ? rd_data : hold_q;
        if (!stall) begin
          idx_d   = idx_q + AW'(1);
          state_d = (idx_q == SCR_LAST_IDX) ? ST_FILL : ST_SCR_RD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// VRAM port A arbiter: host has absolute priority over the bulk engine.
// Tracks who issued the last read so bram_douta goes to the right consumer.
module vram_port_arbiter
  import vram_pkg::*;
(
  input logic                Clk,
  input logic                Reset,
  vram_port_arbiter_if.slave bus
);

  logic          eng_req, eng_we, eng_busy, eng_done, eng_ready, eng_rd_ret;
  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_wdata;
  logic          host_in_range, host_rd, eng_rd;
  logic          rd_pend_q, rd_oor_q;
  owner_e        owner_q;
  logic [31:0]   rdata_q, ret_data;

  assign host_in_range = bus.host_addr < AW'(WORDS);
  assign host_rd       = ~Reset & bus.host_req & ~bus.host_we;
  assign eng_rd        = ~Reset & ~bus.host_req & eng_req & ~eng_we;

  vram_bulk_engine u_engine (
    .clk       (Clk),
    .rst       (Reset),
    .stall     (bus.host_req),
    .cmd_valid (bus.cmd_valid),
    .cmd_op    (bus.cmd_op),
    .cmd_fill  (bus.cmd_fill),
    .rd_ret    (eng_rd_ret),
    .rd_data   (bus.bram_douta),
    .cmd_ready (eng_ready),
    .busy      (eng_busy),
    .done      (eng_done),
    .req       (eng_req),
    .we        (eng_we),
    .addr      (eng_addr),
    .wdata     (eng_wdata)
  );

  always_comb begin
    bus.host_gnt   = bus.host_req & ~Reset;
    bus.bram_ena   = 1'b0;
    bus.bram_wea   = 4'h0;
    bus.bram_addra = bus.host_addr;
    bus.bram_dina  = bus.host_wdata;
    if (!Reset) begin
      if (bus.host_req) begin
        // out-of-range host accesses are granted but never reach the BRAM
        bus.bram_ena = host_in_range;
        if (bus.host_we && host_in_range) bus.bram_wea = bus.host_wstrb;
      end else if (eng_req) begin
        bus.bram_ena   = 1'b1;
        bus.bram_wea   = eng_we ? 4'hF : 4'h0;
        bus.bram_addra = eng_addr;
        bus.bram_dina  = eng_wdata;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_pend_q <= 1'b0;
      rd_oor_q  <= 1'b0;
      owner_q   <= OWN_HOST;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= host_rd | eng_rd;
      rd_oor_q  <= host_rd & ~host_in_range;
      if (host_rd)     owner_q <= OWN_HOST;
      else if (eng_rd) owner_q <= OWN_ENGINE;
      if (bus.host_rvalid) rdata_q <= ret_data;
    end
  end

  assign eng_rd_ret      = rd_pend_q & (owner_q == OWN_ENGINE);
  assign ret_data        = rd_oor_q ? 32'h0 : bus.bram_douta;
  // return data is presented in the rvalid cycle and held afterwards
  assign bus.host_rvalid = rd_pend_q & (owner_q == OWN_HOST);
  assign bus.host_rdata  = bus.host_rvalid ? ret_data : rdata_q;

  assign bus.cmd_ready = eng_ready;
  assign bus.busy      = eng_busy & ~Reset;
  assign bus.done      = eng_done & ~Reset;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter with a BRAM model and a word-level
// reference memory; randomized host traffic plus directed bulk-command steps.
module tb_vram_port_arbiter;
  import vram_pkg::*;

  logic Clk;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  vram_port_arbiter_if bus();

  vram_port_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // BRAM port A: read-first, 1-cycle latency, byte write enables
  logic [31:0] mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
  always @(posedge Clk) begin
    if (bus.bram_ena && (int'(bus.bram_addra) < WORDS)) begin
      bus.bram_douta <= mem[bus.bram_addra];
      for (int b = 0; b < 4; b++)
        if (bus.bram_wea[b]) mem[bus.bram_addra][8*b +: 8] <= bus.bram_dina[8*b +: 8];
    end
  end

  logic [31:0] ref_mem [WORDS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int a, input logic [31:0] d, input logic [3:0] s);
    bit inr;
    inr = (a < WORDS);
    @(negedge Clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = AW'(a);
    bus.host_wdata = d; bus.host_wstrb = s;
    #1;
    chk("wr_gnt", 32'(bus.host_gnt), 32'd1);
    chk("wr_ena", 32'(bus.bram_ena), 32'(inr));
    chk("wr_wea", 32'(bus.bram_wea), inr ? 32'(s) : 32'd0);
    if (inr)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    @(negedge Clk);
    bus.host_req = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic host_read(input int a, input string tag);
    logic [31:0] exp;
    exp = (a < WORDS) ? ref_mem[a] : 32'h0;
    @(negedge Clk);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = AW'(a);
    #1;
    chk({tag, "_gnt"}, 32'(bus.host_gnt), 32'd1);
    chk({tag, "_ena"}, 32'(bus.bram_ena), 32'(a < WORDS));
    @(negedge Clk);
    bus.host_req = 1'b0;
    #1;
    chk({tag, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
    chk({tag, "_rdata"}, bus.host_rdata, exp);
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] fill);
    @(negedge Clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_fill = fill;
    @(negedge Clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    #1;
  endtask

  // Counts busy cycles up to the done pulse; optional ignored command and
  // alternating random host reads that steal port A from the engine.
  task automatic wait_bulk(input int max, input int inject_at, input bit steal,
                           output int busy_n, output int done_n, output int stolen);
    bit          prev_rd;
    logic [31:0] prev_exp;
    int          a;
    busy_n = 0; done_n = 0; stolen = 0; prev_rd = 0; prev_exp = '0;
    for (int k = 0; k < max; k++) begin
      if (prev_rd) begin
        chk("scr_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("scr_host_rdata", bus.host_rdata, prev_exp);
      end
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      bus.cmd_valid = (k == inject_at);
      bus.cmd_op    = 2'b10;
      bus.cmd_fill  = 32'hFFFF_FFFF;
      bus.host_req  = 1'b0;
      prev_rd       = 1'b0;
      if (steal && !bus.done && (k % 2 == 1)) begin
        a = int'($urandom_range(0, WORDS - 1));
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = AW'(a);
        prev_exp = mem[a];
        prev_rd  = 1'b1;
        if (bus.busy) stolen++;
      end
      if (bus.done) break;
      @(negedge Clk);
      #1;
    end
    bus.cmd_valid = 1'b0; bus.host_req = 1'b0;
    @(negedge Clk);
    #1;
    chk("post_done_low", 32'(bus.done), 32'd0);
    chk("post_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic preload_index();
    for (int i = 0; i < WORDS; i++) host_write(i, 32'(i), 4'hF);
  endtask

  task automatic check_scroll_image(input logic [31:0] fill, input string tag);
    int          mism;
    logic [31:0] exp;
    mism = 0;
    for (int i = 0; i < WORDS; i++) begin
      exp = (i < WORDS - ROW_WORDS) ? 32'(i + ROW_WORDS) : fill;
      if (mem[i] !== exp) mism++;
      ref_mem[i] = exp;
    end
    chk({tag, "_mismatches"}, 32'(mism), 32'd0);
    chk({tag, "_w0"}, mem[0], 32'd20);
    chk({tag, "_w579"}, mem[579], 32'd599);
    chk({tag, "_w580"}, mem[580], fill);
  endtask

  initial begin
    int busy_n, done_n, stolen, mism, a;
    logic [31:0] d;
    logic [3:0]  s;

    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_wstrb = '0;
    bus.cmd_valid = 0; bus.cmd_op = 2'b00; bus.cmd_fill = '0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_ena", 32'(bus.bram_ena), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_rdata", bus.host_rdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

    host_write(5, 32'hDEADBEEF, 4'hF);
    host_read(5, "rd5");
    @(negedge Clk); #1;
    chk("rd5_hold", bus.host_rdata, 32'hDEADBEEF);

    // random host traffic, including partial strobes and out-of-range words
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WORDS, 1023))
                                      : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        host_write(a, d, s);
      end else begin
        host_read(a, "rnd_rd");
      end
    end

    host_read(600, "oor_rd");
    host_write(700, 32'h1234_5678, 4'hF);

    // CLEAR with an ignored SCROLL arriving while busy
    issue_cmd(OP_CLEAR, 32'h2020_2020);
    wait_bulk(2000, 5, 1'b0, busy_n, done_n, stolen);
    chk("clr_busy_cycles", 32'(busy_n), 32'd600);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    mism = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== 32'h2020_2020) mism++;
      ref_mem[i] = 32'h2020_2020;
    end
    chk("clr_image", 32'(mism), 32'd0);
    host_read(0, "clr_rd0");
    host_read(299, "clr_rd299");
    host_read(599, "clr_rd599");

    @(negedge Clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_fill = 32'hAAAA_AAAA;
    @(negedge Clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    #1;
    chk("nop_busy", 32'(bus.busy), 32'd0);
    chk("nop_ready", 32'(bus.cmd_ready), 32'd1);

    preload_index();
    issue_cmd(OP_SCROLL, 32'h2E2E_2E2E);
    wait_bulk(4000, -1, 1'b0, busy_n, done_n, stolen);
    chk("scr_busy_cycles", 32'(busy_n), 32'd1180);
    chk("scr_done_pulses", 32'(done_n), 32'd1);
    check_scroll_image(32'h2E2E_2E2E, "scr");

    preload_index();
    issue_cmd(OP_SCROLL, 32'h2E2E_2E2E);
    wait_bulk(6000, -1, 1'b1, busy_n, done_n, stolen);
    chk("cscr_stolen_nonzero", 32'(stolen > 500), 32'd1);
    chk("cscr_busy_cycles", 32'(busy_n), 32'(1180 + stolen));
    chk("cscr_done_pulses", 32'(done_n), 32'd1);
    check_scroll_image(32'h2E2E_2E2E, "cscr");

    // reset 50 cycles into a CLEAR
    issue_cmd(OP_CLEAR, 32'h55AA_55AA);
    repeat (49) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rstcmd_no_ena", 32'(bus.bram_ena), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rstcmd_busy", 32'(bus.busy), 32'd0);
    chk("rstcmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstcmd_done", 32'(bus.done), 32'd0);
    chk("rstcmd_w0_written", mem[0], 32'h55AA_55AA);
    chk("rstcmd_w599_kept", mem[599], 32'h2E2E_2E2E);
    chk("rstcmd_w100_kept", mem[100], 32'd120);
    issue_cmd(OP_CLEAR, 32'h0F0F_0F0F);
    wait_bulk(2000, -1, 1'b0, busy_n, done_n, stolen);
    chk("rclr_busy_cycles", 32'(busy_n), 32'd600);
    chk("rclr_done_pulses", 32'(done_n), 32'd1);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0F0F_0F0F;
    host_read(0, "rclr_rd0");
    host_read(599, "rclr_rd599");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
